// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the unified memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 32;
  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_MEM_LATENCY  = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int STAT_WIDTH           = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

  // Bits needed to hold 0..max_value, never less than one.
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_tracker.sv
// ============================================================================
// Module      : mem_arb_starve_tracker
// Description : MEM-first grant selection with a saturating IF starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_tracker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_idle_i,
  input  logic if_request_i,
  input  logic mem_request_i,
  output logic grant_if_o,
  output logic grant_mem_o
);

  localparam int            SW    = cnt_width(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starved;

  assign starved = (starve_q == LIMIT);

  always_comb begin
    grant_if_o  = arb_idle_i & if_request_i & (~mem_request_i | starved);
    grant_mem_o = arb_idle_i & mem_request_i & ~grant_if_o;
    starve_d    = starve_q;
    if (grant_if_o) begin
      starve_d = '0;
    end else if (grant_mem_o && if_request_i && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/unified_memory_arbiter.sv
// ============================================================================
// Module      : unified_memory_arbiter
// Description : Shares one single-port synchronous RAM between IF and MEM.
//               Define MEM_ARB_STATS_EN to add grant/conflict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  if_stall,
  input  logic                  mem_request,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_readData,
  output logic                  mem_stall,
  output logic                  ram_enable,
  output logic                  ram_writeEnable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_writeData,
  input  logic [DATA_WIDTH-1:0] ram_readData
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_ifGrants,
  output logic [STAT_WIDTH-1:0] stat_memGrants,
  output logic [STAT_WIDTH-1:0] stat_conflictCycles
`endif
);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("unified_memory_arbiter: MEM_LATENCY must be >= 1");
    end
  endgenerate

  localparam int            CW       = cnt_width(MEM_LATENCY);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY);

  arb_state_t            state_q;
  logic [CW-1:0]         lat_cnt_q;
  logic                  ram_enable_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [DATA_WIDTH-1:0] hold_wdata_q;
  logic                  hold_write_q;

  logic   grant_if;
  logic   grant_mem;
  logic   xfer_done;
  owner_t active_owner;

  mem_arb_starve_tracker #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock         (clock),
    .reset         (reset),
    .arb_idle_i    (state_q == IDLE),
    .if_request_i  (if_request),
    .mem_request_i (mem_request),
    .grant_if_o    (grant_if),
    .grant_mem_o   (grant_mem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      ram_enable_q <= 1'b0;
      ram_we_q     <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ram_enable_q <= 1'b0;
          ram_we_q     <= 1'b0;
          if (grant_mem) begin
            state_q      <= BUSY_MEM;
            lat_cnt_q    <= LAT_LOAD;
            ram_enable_q <= 1'b1;
            ram_we_q     <= mem_write;
            hold_addr_q  <= mem_address;
            hold_wdata_q <= mem_writeData;
            hold_write_q <= mem_write;
          end else if (grant_if) begin
            state_q      <= BUSY_IF;
            lat_cnt_q    <= LAT_LOAD;
            ram_enable_q <= 1'b1;
            ram_we_q     <= 1'b0;
            hold_addr_q  <= if_address;
            hold_wdata_q <= '0;
            hold_write_q <= 1'b0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          // The strobe covers only the first busy cycle; the counter then runs out the latency.
          ram_enable_q <= 1'b0;
          ram_we_q     <= 1'b0;
          if (lat_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - CW'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          ram_enable_q <= 1'b0;
          ram_we_q     <= 1'b0;
        end
      endcase
    end
  end

  assign active_owner = (state_q == BUSY_MEM) ? OWNER_MEM : OWNER_IF;
  assign xfer_done    = (state_q != IDLE) && (lat_cnt_q == '0);

  assign if_ready  = xfer_done && (active_owner == OWNER_IF);
  assign mem_ready = xfer_done && (active_owner == OWNER_MEM);
  assign if_stall  = if_request & ~if_ready;
  assign mem_stall = mem_request & ~mem_ready;

  assign if_instruction = if_ready ? ram_readData : '0;
  assign mem_readData   = (mem_ready && !hold_write_q) ? ram_readData : '0;

  assign ram_enable      = ram_enable_q;
  assign ram_writeEnable = ram_we_q;
  assign ram_address     = hold_addr_q;
  assign ram_writeData   = hold_wdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_if_q;
  logic [STAT_WIDTH-1:0] stat_mem_q;
  logic [STAT_WIDTH-1:0] stat_conf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_if_q   <= '0;
      stat_mem_q  <= '0;
      stat_conf_q <= '0;
    end else begin
      if (grant_if) begin
        stat_if_q <= stat_if_q + STAT_WIDTH'(1);
      end
      if (grant_mem) begin
        stat_mem_q <= stat_mem_q + STAT_WIDTH'(1);
      end
      if ((state_q == IDLE) && if_request && mem_request) begin
        stat_conf_q <= stat_conf_q + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_ifGrants       = stat_if_q;
  assign stat_memGrants      = stat_mem_q;
  assign stat_conflictCycles = stat_conf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_unified_memory_arbiter.sv
// ============================================================================
// Module      : tb_unified_memory_arbiter
// Description : Directed self-checking bench for unified_memory_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unified_memory_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_request;
  logic [31:0] if_address;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic        if_stall;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_ready;
  logic [31:0] mem_readData;
  logic        mem_stall;
  logic        ram_enable;
  logic        ram_writeEnable;
  logic [31:0] ram_address;
  logic [31:0] ram_writeData;
  logic [31:0] ram_readData;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ifGrants;
  logic [31:0] stat_memGrants;
  logic [31:0] stat_conflictCycles;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  unified_memory_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .MEM_LATENCY  (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .if_request      (if_request),
    .if_address      (if_address),
    .if_ready        (if_ready),
    .if_instruction  (if_instruction),
    .if_stall        (if_stall),
    .mem_request     (mem_request),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_writeData   (mem_writeData),
    .mem_ready       (mem_ready),
    .mem_readData    (mem_readData),
    .mem_stall       (mem_stall),
    .ram_enable      (ram_enable),
    .ram_writeEnable (ram_writeEnable),
    .ram_address     (ram_address),
    .ram_writeData   (ram_writeData),
    .ram_readData    (ram_readData)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ifGrants       (stat_ifGrants),
    .stat_memGrants      (stat_memGrants),
    .stat_conflictCycles (stat_conflictCycles)
`endif
  );

  // Flag vector order: {ram_enable, ram_writeEnable, if_ready, mem_ready, if_stall, mem_stall}
  logic [5:0] flags;
  assign flags = {ram_enable, ram_writeEnable, if_ready, mem_ready, if_stall, mem_stall};

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    if_request    = 1'b0;
    if_address    = '0;
    mem_request   = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    ram_readData  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++;
    if (flags !== 6'b000000) $display("FAIL reset_flags: got %b expected %b", flags, 6'b000000);
    else n_pass++;
    n_total++;
    if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    else n_pass++;
    n_total++;
    if ({ram_address, ram_writeData, if_instruction, mem_readData} !== 128'h0)
      $display("FAIL reset_data: got %h %h %h %h expected all 0", ram_address, ram_writeData, if_instruction, mem_readData);
    else n_pass++;
    n_total++;
    if (dut.u_starve.starve_q !== 3'd0) $display("FAIL reset_starve: got %0d expected 0", dut.u_starve.starve_q);
    else n_pass++;
  endtask

  task automatic test_if_fetch();
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) begin
        if_request   = 1'b1;
        if_address   = 32'h0000_0040;
        ram_readData = 32'h2402_0005;
      end
      #1;
      exp = {c == 1, 1'b0, c == 3, 1'b0, c < 3, 1'b0};
      n_total++;
      if (flags !== exp) $display("FAIL if_fetch_flags c%0d: got %b expected %b", c, flags, exp);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if (ram_address !== 32'h40) $display("FAIL if_fetch_addr: got %h expected %h", ram_address, 32'h40);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (if_instruction !== 32'h2402_0005) $display("FAIL if_fetch_data: got %h expected %h", if_instruction, 32'h2402_0005);
        else n_pass++;
      end
      tick();
    end
    if_request = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) begin
        if_request   = 1'b1;
        if_address   = 32'h0000_0044;
        mem_request  = 1'b1;
        mem_write    = 1'b0;
        mem_address  = 32'h0000_1000;
        ram_readData = 32'h1111_2222;
      end
      if (c == 4) mem_request = 1'b0;
      #1;
      exp = {c == 1 || c == 5, 1'b0, c == 7, c == 3, c < 7, c < 3};
      n_total++;
      if (flags !== exp) $display("FAIL conflict_flags c%0d: got %b expected %b", c, flags, exp);
      else n_pass++;
      if (c == 1 || c == 5) begin
        n_total++;
        if (ram_address !== ((c == 1) ? 32'h1000 : 32'h44))
          $display("FAIL conflict_addr c%0d: got %h expected %h", c, ram_address, (c == 1) ? 32'h1000 : 32'h44);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (mem_readData !== 32'h1111_2222) $display("FAIL conflict_load_data: got %h expected %h", mem_readData, 32'h1111_2222);
        else n_pass++;
      end
      if (c == 7) begin
        n_total++;
        if (if_instruction !== 32'h1111_2222) $display("FAIL conflict_fetch_data: got %h expected %h", if_instruction, 32'h1111_2222);
        else n_pass++;
      end
      tick();
    end
    if_request = 1'b0;
    tick();
`ifdef MEM_ARB_STATS_EN
    n_total++;
    if ({stat_ifGrants, stat_memGrants, stat_conflictCycles} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL stats: got if=%0d mem=%0d conf=%0d expected 1 1 1", stat_ifGrants, stat_memGrants, stat_conflictCycles);
    else n_pass++;
`endif
  endtask

  task automatic test_store();
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) begin
        mem_request   = 1'b1;
        mem_write     = 1'b1;
        mem_address   = 32'h0000_2000;
        mem_writeData = 32'hDEAD_BEEF;
        ram_readData  = 32'h5555_5555;
      end
      #1;
      exp = {c == 1, c == 1, 1'b0, c == 3, 1'b0, c < 3};
      n_total++;
      if (flags !== exp) $display("FAIL store_flags c%0d: got %b expected %b", c, flags, exp);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if ({ram_address, ram_writeData} !== {32'h2000, 32'hDEAD_BEEF})
          $display("FAIL store_bus: got %h/%h expected %h/%h", ram_address, ram_writeData, 32'h2000, 32'hDEAD_BEEF);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (mem_readData !== 32'h0) $display("FAIL store_readdata: got %h expected %h", mem_readData, 32'h0);
        else n_pass++;
      end
      tick();
    end
    mem_request = 1'b0;
    mem_write   = 1'b0;
    tick();
  endtask

  task automatic test_drop_midway();
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) begin
        if_request   = 1'b1;
        if_address   = 32'h0000_0100;
        ram_readData = 32'hCAFE_0001;
      end
      if (c == 1) if_request = 1'b0;
      #1;
      exp = {c == 1, 1'b0, c == 3, 1'b0, c == 0, 1'b0};
      n_total++;
      if (flags !== exp) $display("FAIL drop_flags c%0d: got %b expected %b", c, flags, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_starvation();
    int  mem_grants = 0;
    int  max_starve = 0;
    bit  if_done    = 1'b0;
    bit  first_seen = 1'b0;
    do_reset();
    if_request   = 1'b1;
    if_address   = 32'h0000_0080;
    mem_request  = 1'b1;
    mem_write    = 1'b0;
    mem_address  = 32'h0000_3000;
    ram_readData = 32'h0BAD_F00D;
    for (int c = 0; c < 60 && !if_done; c++) begin
      #1;
      if (int'(dut.u_starve.starve_q) > max_starve) max_starve = int'(dut.u_starve.starve_q);
      if (ram_enable && !first_seen) begin
        first_seen = 1'b1;
        n_total++;
        if (ram_address !== 32'h3000) $display("FAIL starve_first_grant: got %h expected %h", ram_address, 32'h3000);
        else n_pass++;
      end
      if (ram_enable && ram_address == 32'h3000) mem_grants++;
      if (if_ready) begin
        if_done = 1'b1;
        n_total++;
        if (dut.u_starve.starve_q !== 3'd0) $display("FAIL starve_cleared: got %0d expected 0", dut.u_starve.starve_q);
        else n_pass++;
        if_request  = 1'b0;
        mem_request = 1'b0;
      end
      tick();
    end
    n_total++;
    if (!if_done) $display("FAIL starve_if_timeout: got no if_ready expected one within 60 cycles");
    else n_pass++;
    n_total++;
    if (mem_grants !== 4) $display("FAIL starve_mem_grants: got %0d expected 4", mem_grants);
    else n_pass++;
    n_total++;
    if (max_starve !== 4) $display("FAIL starve_peak: got %0d expected 4", max_starve);
    else n_pass++;
    if_request  = 1'b0;
    mem_request = 1'b0;
    tick();
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) begin
        mem_request  = 1'b1;
        mem_write    = 1'b0;
        mem_address  = 32'h0000_1000;
        ram_readData = 32'h7777_8888;
      end
      if (c == 2) begin
        reset       = 1'b1;
        mem_request = 1'b0;
      end
      if (c == 3) reset = 1'b0;
      #1;
      if (c >= 2) begin
        n_total++;
        if ({ram_enable, mem_ready} !== 2'b00) $display("FAIL rst_mid_strobes c%0d: got %b expected %b", c, {ram_enable, mem_ready}, 2'b00);
        else n_pass++;
      end
      if (c >= 3) begin
        n_total++;
        if (dut.state_q !== IDLE) $display("FAIL rst_mid_state c%0d: got %0d expected %0d", c, dut.state_q, IDLE);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_conflict();
    test_store();
    test_drop_midway();
    test_starvation();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

`default_nettype wire
